fetch_admin: RTL

- Producer side of the instruction-buffer fill interface.
- Each fetch request (fetch_inst pulse from the instruction buffer) turns into one 16-byte I-cache block fetch.
- Converts the I-cache response plus branch-predictor hints into one admin2ib delivery: 4 instruction slots, a per-slot valid mask, per-slot predict-taken/target, and the block base pc.
- Owns the fetch PC: sequential advance, predicted-taken redirect and backend redirect, including discard of stale in-flight responses.

---
 rtl/fetch_admin.sv | 93 +++++++++
 1 files changed

// File: rtl/fetch_admin.sv
// fetch_admin: owns the fetch PC and turns 16-byte I-cache blocks plus predictor hints
// into one-cycle instruction-buffer deliveries, discarding responses made stale by redirects.
module fetch_admin #(
  parameter logic [63:0] RESET_PC    = 64'h8000_0000,
  parameter int          BLOCK_BYTES = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         fetch_inst,
  input  logic         redirect_valid,
  input  logic [63:0]  redirect_target,
  output logic         ic_req_valid,
  input  logic         ic_req_ready,
  output logic [63:0]  ic_req_addr,
  input  logic         ic_resp_valid,
  input  logic [127:0] ic_resp_data,
  input  logic [3:0]   bp_predicttaken,
  input  logic [127:0] bp_predicttarget,
  output logic [127:0] admin2ib_instr,
  output logic [3:0]   admin2ib_instr_valid,
  output logic [3:0]   admin2ib_predicttaken,
  output logic [127:0] admin2ib_predicttarget,
  output logic [63:0]  pc
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;
  localparam logic [63:0] BLK = 64'(BLOCK_BYTES);
  state_t        state_q;
  logic          pending_q;
  logic [63:0]   fetch_pc_q, blk_pc, npc_d;
  logic [3:0]    base_m, hit, mask_d, valid_q, taken_q;
  logic [1:0]    t;
  logic [31:0]   tgt;
  logic [127:0]  instr_q, target_q;
  logic [63:0]   pc_q;
  assign blk_pc = fetch_pc_q & ~(BLK - 64'd1);
  // Slots before the entry offset are never valid; the first taken slot ends the block.
  always_comb begin
    base_m = 4'b1111 << fetch_pc_q[3:2];
    hit    = base_m & bp_predicttaken;
    t      = hit[0] ? 2'd0 : hit[1] ? 2'd1 : hit[2] ? 2'd2 : 2'd3;
    tgt    = bp_predicttarget[32*t +: 32];
    mask_d = |hit ? base_m & 4'((5'd2 << t) - 5'd1) : base_m;
    npc_d  = |hit ? {32'b0, tgt} : blk_pc + BLK;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pending_q  <= 1'b1;
      fetch_pc_q <= RESET_PC;
      valid_q    <= '0;
      taken_q    <= '0;
      instr_q    <= '0;
      target_q   <= '0;
      pc_q       <= RESET_PC & ~(BLK - 64'd1);
    end else begin
      valid_q <= '0;
      if (redirect_valid) begin
        fetch_pc_q <= redirect_target;
        pending_q  <= 1'b1;
        // An accepted-but-unanswered request still owes a response that must be swallowed.
        state_q <= ((state_q == REQ && ic_req_ready) ||
                    ((state_q == WAIT || state_q == DRAIN) && !ic_resp_valid)) ? DRAIN : IDLE;
      end else begin
        if (fetch_inst) pending_q <= 1'b1;
        case (state_q)
          IDLE: if (pending_q || fetch_inst) begin
            state_q   <= REQ;
            pending_q <= 1'b0;
          end
          REQ:  if (ic_req_ready) state_q <= WAIT;
          WAIT: if (ic_resp_valid) begin
            valid_q    <= mask_d;
            taken_q    <= bp_predicttaken & mask_d;
            instr_q    <= ic_resp_data;
            target_q   <= bp_predicttarget;
            pc_q       <= blk_pc;
            fetch_pc_q <= npc_d;
            state_q    <= IDLE;
          end
          DRAIN: if (ic_resp_valid) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end
  assign ic_req_valid           = state_q == REQ;
  assign ic_req_addr            = blk_pc;
  assign admin2ib_instr         = instr_q;
  assign admin2ib_instr_valid   = valid_q;
  assign admin2ib_predicttaken  = taken_q;
  assign admin2ib_predicttarget = target_q;
  assign pc                     = pc_q;
endmodule
